// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the pentaRV instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: FSM state enum, bubble encoding, default reset PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,  // request driven at PCF
    S_WAIT = 3'd1,  // one request outstanding, waiting for rvalid
    S_HOLD = 3'd2,  // returned word parked in hold_q while decode stalls
    S_KILL = 3'd3,  // outstanding response belongs to an abandoned path
    S_HALT = 3'd4   // fetch stopped after a misaligned redirect
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_if_id_reg.sv
// fetch_if_id_reg: IF/ID pipeline register (instrD, PCD, PCPlus4D, validD).
// Latency: 1 cycle from i_load to outputs.
// Backpressure: i_hold freezes contents; i_bubble overrides hold and load.
// Ports: i_clk/i_rst (sync, active-high), i_load/i_bubble/i_hold controls,
//        i_instr/i_pc payload, o_instr/o_pc/o_pc_plus4/o_valid register contents.
module fetch_if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic        i_hold,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Priority: reset, bubble (flush/redirect), hold (stall), load, else bubble.
  // A bubble only replaces the instruction; PCD/PCPlus4D keep their last value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'h0000_0000;
      r_pc_plus4 <= 32'h0000_0004;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_instr    <= i_instr;
        r_pc       <= i_pc;
        r_pc_plus4 <= i_pc + 32'd4;
        r_valid    <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch.sv
// fetch: pentaRV IF stage; owns PCF, single-outstanding imem req/ready+rvalid, feeds IF/ID.
// Latency: accept -> validD is 1 + memory latency; 1 instr/cycle with zero-wait memory.
// Backpressure: StallD parks a returned word in hold_q and stops requesting until release.
// Ports: clk, rst (sync active-high); StallD/FlushD from hazard unit; PCSrcE/PCTargetE
//        redirect; imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata memory port;
//        instrD/PCD/PCPlus4D/validD IF/ID outputs; fetch_err sticky misalign flag.
// Optional: FETCH_MISALIGN_CHK_EN enables misaligned-redirect detection and HALT.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD,
  output logic        fetch_err
);

  fetch_state_t r_state, w_state_nxt, w_go_idle;
  logic [31:0]  r_pcf, w_pcf_nxt, w_pcf_plus4;
  logic [31:0]  r_hold;
  logic [31:0]  w_target;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_addr;
  logic         w_load, w_hold_cap, w_req;
  logic         w_err_nxt, w_fetch_err;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fetch_err;
  logic w_redirect_bad;

  assign w_target       = PCTargetE;
  assign w_redirect_bad = PCSrcE && (PCTargetE[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)                 r_fetch_err <= 1'b0;
    else if (w_redirect_bad) r_fetch_err <= 1'b1;
  end

  assign w_err_nxt   = r_fetch_err | w_redirect_bad;
  assign w_fetch_err = r_fetch_err;
`else
  // Low address bits are dropped so a redirect can never be misaligned.
  assign w_target    = PCTargetE & 32'hFFFF_FFFC;
  assign w_err_nxt   = 1'b0;
  assign w_fetch_err = 1'b0;
`endif

  assign w_pcf_plus4 = r_pcf + 32'd4;
  // Where the FSM lands once no response is pending: HALT once an error is seen.
  assign w_go_idle   = w_err_nxt ? S_HALT : S_REQ;

  always_comb begin
    w_state_nxt  = r_state;
    w_pcf_nxt    = r_pcf;
    w_load       = 1'b0;
    w_load_instr = imem_rdata;
    w_hold_cap   = 1'b0;
    w_req        = 1'b0;
    w_addr       = r_pcf;
    case (r_state)
      S_REQ: begin
        w_req = 1'b1;
        if (PCSrcE)          w_state_nxt = imem_ready ? S_KILL : w_go_idle;
        else if (imem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (PCSrcE) begin
          w_state_nxt = imem_rvalid ? w_go_idle : S_KILL;
        end else if (imem_rvalid) begin
          if (StallD) begin
            w_hold_cap  = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            // Back-to-back request in the delivery cycle (rvalid -> req path).
            w_load      = 1'b1;
            w_pcf_nxt   = w_pcf_plus4;
            w_req       = 1'b1;
            w_addr      = w_pcf_plus4;
            w_state_nxt = imem_ready ? S_WAIT : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_state_nxt = w_go_idle;
        end else if (!StallD) begin
          w_load       = 1'b1;
          w_load_instr = r_hold;
          w_pcf_nxt    = w_pcf_plus4;
          w_state_nxt  = S_REQ;
        end
      end
      S_KILL: begin
        if (imem_rvalid) w_state_nxt = w_go_idle;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (PCSrcE) w_pcf_nxt = w_target;
  end

  // On reset a still-pending response must be swallowed, so a request that was
  // outstanding (and not answered in this very cycle) leaves us in KILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((r_state == S_WAIT || r_state == S_KILL) && !imem_rvalid) r_state <= S_KILL;
      else                                                          r_state <= S_REQ;
      r_pcf  <= RESET_PC;
      r_hold <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pcf   <= w_pcf_nxt;
      if (w_hold_cap) r_hold <= imem_rdata;
    end
  end

  assign imem_req  = w_req && !rst;
  assign imem_addr = w_addr;
  assign fetch_err = w_fetch_err;

  fetch_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_bubble   (PCSrcE | FlushD),
    .i_hold     (StallD),
    .i_instr    (w_load_instr),
    .i_pc       (r_pcf),
    .o_instr    (instrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (validD)
  );

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: cycle-by-cycle directed vectors for the fetch stage.
// Each row drives one cycle of hazard/redirect/memory inputs and lists the
// expected memory request and IF/ID contents for that cycle.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, StallD, FlushD, PCSrcE, imem_ready, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, validD, fetch_err;
  logic [31:0] imem_addr, instrD, PCD, PCPlus4D;

  int n_chk  = 0;
  int n_fail = 0;

  fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instrD      (instrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic        rst, stall, flush, pcsrc;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pcd;
    logic        e_vld, e_err;
  } vec_t;

  vec_t vecs[$];

  // Instruction word tagged with its address so misdelivery is visible.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  function automatic vec_t row(
    input logic rst_i, stall, flush, pcsrc, input logic [31:0] tgt,
    input logic rdy, rv, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, e_instr, e_pcd,
    input logic e_vld, e_err);
    vec_t v;
    v.rst = rst_i; v.stall = stall; v.flush = flush; v.pcsrc = pcsrc; v.tgt = tgt;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pcd = e_pcd;
    v.e_vld = e_vld; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //                 rst st fl pc tgt           rdy rv rdata            req addr          instr             pcd           vld err
    // straight-line, zero-wait memory
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h0,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h0),       1, 32'h4,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h4),       1, 32'h8,         ins(32'h0),       32'h0,        1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h8),       1, 32'hC,         ins(32'h4),       32'h4,        1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'hC),       1, 32'h10,        ins(32'h8),       32'h8,        1, 0));
    // ready low 3 cycles, rvalid two cycles after accept
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            1, 32'h10,        ins(32'hC),       32'hC,        1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            1, 32'h10,        NOP,              32'hC,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            1, 32'h10,        NOP,              32'hC,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h10,        NOP,              32'hC,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            0, 32'h0,         NOP,              32'hC,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'h10),      1, 32'h14,        NOP,              32'hC,        0, 0));
    // StallD high 4 cycles across rvalid
    vecs.push_back(row(0, 1, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h14,        ins(32'h10),      32'h10,       1, 0));
    vecs.push_back(row(0, 1, 0, 0, 32'h0,         0, 1, ins(32'h14),      0, 32'h0,         ins(32'h10),      32'h10,       1, 0));
    vecs.push_back(row(0, 1, 0, 0, 32'h0,         0, 0, 32'h0,            0, 32'h0,         ins(32'h10),      32'h10,       1, 0));
    vecs.push_back(row(0, 1, 0, 0, 32'h0,         0, 0, 32'h0,            0, 32'h0,         ins(32'h10),      32'h10,       1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            0, 32'h0,         ins(32'h10),      32'h10,       1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h18,        ins(32'h14),      32'h14,       1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h18),      1, 32'h1C,        NOP,              32'h14,       0, 0));
    // redirect while WAIT, stale response discarded in KILL
    vecs.push_back(row(0, 0, 0, 1, 32'h100,       0, 0, 32'h0,            0, 32'h0,         ins(32'h18),      32'h18,       1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h1C),      0, 32'h0,         NOP,              32'h18,       0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h100,       NOP,              32'h18,       0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'h100),     1, 32'h104,       NOP,              32'h18,       0, 0));
    // FlushD beats StallD
    vecs.push_back(row(0, 1, 1, 0, 32'h0,         0, 0, 32'h0,            1, 32'h104,       ins(32'h100),     32'h100,      1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h104,       NOP,              32'h100,      0, 0));
    // redirect coinciding with rvalid: data dropped, request next cycle
    vecs.push_back(row(0, 0, 0, 1, 32'h200,       1, 1, ins(32'h104),     0, 32'h0,         NOP,              32'h100,      0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h200,       NOP,              32'h100,      0, 0));
    // rst while WAIT; stale rvalid after reset ignored
    vecs.push_back(row(1, 0, 0, 0, 32'h0,         0, 0, 32'h0,            0, 32'h0,         NOP,              32'h100,      0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'h200),     0, 32'h0,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'h0,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'h0),       1, 32'h4,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            1, 32'h4,         ins(32'h0),       32'h0,        1, 0));
    // redirect in REQ (not accepted) to the top of memory; PC wraps
    vecs.push_back(row(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,            1, 32'h4,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            1, 32'hFFFF_FFFC, NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 1, ins(32'hFFFF_FFFC), 1, 32'h0,       NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'h0),       1, 32'h4,         ins(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            1, 32'h4,         ins(32'h0),       32'h0,        1, 0));
    // misaligned redirect: masked by default, halts fetch when checking is enabled
    vecs.push_back(row(0, 0, 0, 1, 32'h102,       0, 0, 32'h0,            1, 32'h4,         NOP,              32'h0,        0, 0));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,            !CHK, 32'h100,    NOP,              32'h0,        0, CHK));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 1, ins(32'h100),     !CHK, 32'h104,    NOP,              32'h0,        0, CHK));
    vecs.push_back(row(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,            !CHK, 32'h104,
                       CHK ? NOP : ins(32'h100), CHK ? 32'h0 : 32'h100, !CHK, CHK));

    // reset state
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset.req",      {31'b0, imem_req},  32'h0);
    chk("reset.instrD",   instrD,             NOP);
    chk("reset.PCD",      PCD,                32'h0);
    chk("reset.PCPlus4D", PCPlus4D,           32'h4);
    chk("reset.validD",   {31'b0, validD},    32'h0);
    chk("reset.err",      {31'b0, fetch_err}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      StallD      = vecs[i].stall;
      FlushD      = vecs[i].flush;
      PCSrcE      = vecs[i].pcsrc;
      PCTargetE   = vecs[i].tgt;
      imem_ready  = vecs[i].rdy;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d.req", i + 1), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req)
        chk($sformatf("row%0d.addr", i + 1), imem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d.instrD", i + 1),   instrD,   vecs[i].e_instr);
      chk($sformatf("row%0d.PCD", i + 1),      PCD,      vecs[i].e_pcd);
      chk($sformatf("row%0d.PCPlus4D", i + 1), PCPlus4D, vecs[i].e_pcd + 32'd4);
      chk($sformatf("row%0d.validD", i + 1),   {31'b0, validD},    {31'b0, vecs[i].e_vld});
      chk($sformatf("row%0d.err", i + 1),      {31'b0, fetch_err}, {31'b0, vecs[i].e_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
